// File: rtl/banked_rotating_fifo_pkg.sv
// banked_rotating_fifo_pkg: default geometry shared by the banked FIFO and its bank storage
//   Exports NUM_DATA_DEF, DATA_WIDTH_DEF and DEPTH_DEF, which serve as the parameter defaults.
package banked_rotating_fifo_pkg;
    localparam int NUM_DATA_DEF   = 4;
    localparam int DATA_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 4;
endpackage

// File: rtl/fifo_bank.sv
// fifo_bank: DEPTH x DATA_WIDTH register file with one synchronous write port and one asynchronous read port
//   clk          clock, write on rising edge
//   we           write enable
//   waddr/wdata  write row and data
//   raddr/rdata  combinational read row and data
module fifo_bank
    import banked_rotating_fifo_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [$clog2(DEPTH)-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]     rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/banked_rotating_fifo.sv
// banked_rotating_fifo: multi-lane circular buffer striped across NUM_DATA banks, feeding a rotating crossbar
//   clk_i           clock
//   arst_ni         synchronous active-low reset
//   push_data_i     items to write, lane 0 oldest
//   push_cnt_i      number of valid push lanes
//   pop_cnt_i       number of head items to release
//   bank_data_o     each bank's entry at its current head row (unrotated)
//   start_select_o  bank holding the oldest entry
//   count_o/free_o  occupied and free entries
//   overflow_o      one-cycle pulse after a rejected push
//   underflow_o     one-cycle pulse after a rejected pop
module banked_rotating_fifo
    import banked_rotating_fifo_pkg::*;
#(
    parameter int NUM_DATA   = NUM_DATA_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0]  push_data_i,
    input  logic [$clog2(NUM_DATA+1)-1:0]        push_cnt_i,
    input  logic [$clog2(NUM_DATA+1)-1:0]        pop_cnt_i,
    output logic [NUM_DATA-1:0][DATA_WIDTH-1:0]  bank_data_o,
    output logic [$clog2(NUM_DATA)-1:0]          start_select_o,
    output logic [$clog2(NUM_DATA*DEPTH+1)-1:0]  count_o,
    output logic [$clog2(NUM_DATA*DEPTH+1)-1:0]  free_o,
    output logic                                 overflow_o,
    output logic                                 underflow_o
);
    localparam int CAP = NUM_DATA * DEPTH;
    localparam int CW  = $clog2(NUM_DATA + 1);
    localparam int SW  = $clog2(NUM_DATA);
    localparam int PW  = $clog2(CAP);
    localparam int NW  = $clog2(CAP + 1);
    localparam int RW  = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [NW-1:0] count;
    logic          overflow, underflow;
    logic          push_ok, pop_ok;
    logic [CW-1:0] push_acc, pop_acc;

    // Acceptance uses start-of-cycle occupancy only, so a same-cycle pop never makes room for a push.
    assign free_o   = NW'(CAP) - count;
    assign push_ok  = push_cnt_i <= CW'(NUM_DATA) && NW'(push_cnt_i) <= free_o;
    assign pop_ok   = pop_cnt_i <= CW'(NUM_DATA) && NW'(pop_cnt_i) <= count;
    assign push_acc = push_ok ? push_cnt_i : '0;
    assign pop_acc  = pop_ok ? pop_cnt_i : '0;

    always_ff @(posedge clk_i)
        if (!arst_ni) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr + PW'(pop_acc);
            wr_ptr    <= wr_ptr + PW'(push_acc);
            count     <= count + NW'(push_acc) - NW'(pop_acc);
            overflow  <= !push_ok;
            underflow <= !pop_ok;
        end

    assign count_o        = count;
    assign overflow_o     = overflow;
    assign underflow_o    = underflow;
    assign start_select_o = rd_ptr[SW-1:0];

    for (genvar b = 0; b < NUM_DATA; b++) begin : g_bank
        logic [SW-1:0] wl;
        logic [RW-1:0] wrow, rrow;
        // Push lane that lands in this bank, counted from the write pointer's bank.
        assign wl = SW'(b) - wr_ptr[SW-1:0];
        // A bank numbered below the pointer's bank sits in the following row.
        assign wrow = wr_ptr[PW-1:SW] + RW'(SW'(b) < wr_ptr[SW-1:0]);
        assign rrow = rd_ptr[PW-1:SW] + RW'(SW'(b) < rd_ptr[SW-1:0]);
        fifo_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_bank (
            .clk   (clk_i),
            .we    (CW'(wl) < push_acc),
            .waddr (wrow),
            .wdata (push_data_i[wl]),
            .raddr (rrow),
            .rdata (bank_data_o[b])
        );
    end
endmodule

// File: tb/tb_banked_rotating_fifo.sv
// tb_banked_rotating_fifo: directed checks of banked_rotating_fifo plus a short queue-model run
module tb_banked_rotating_fifo;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0][7:0] push_data;
    logic [2:0]      push_cnt, pop_cnt;
    logic [3:0][7:0] bank_data;
    logic [1:0]      start_select;
    logic [4:0]      count, free;
    logic            ovf, udf;
    int              checks = 0;
    int              errors = 0;
    logic [7:0]      q[$];

    banked_rotating_fifo #(.NUM_DATA(4), .DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk_i          (clk),
        .arst_ni        (rst_n),
        .push_data_i    (push_data),
        .push_cnt_i     (push_cnt),
        .pop_cnt_i      (pop_cnt),
        .bank_data_o    (bank_data),
        .start_select_o (start_select),
        .count_o        (count),
        .free_o         (free),
        .overflow_o     (ovf),
        .underflow_o    (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [2:0] pc, input logic [31:0] pd, input logic [2:0] pp);
        push_cnt  = pc;
        push_data = pd;
        pop_cnt   = pp;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane(input int i);
        logic [1:0] b;
        b = start_select + 2'(i);
        return bank_data[b];
    endfunction

    initial begin
        rst_n = 1'b0;
        cyc(0, 0, 0);
        cyc(3, 32'hffffffff, 4);
        check("rst_count", count, 0);
        check("rst_free", free, 16);
        check("rst_start", start_select, 0);
        check("rst_ovf", ovf, 0);
        check("rst_udf", udf, 0);
        rst_n = 1'b1;
        cyc(3, 32'h00a2a1a0, 0);
        check("a_count", count, 3);
        check("a_bank0", bank_data[0], 8'ha0);
        check("a_bank1", bank_data[1], 8'ha1);
        check("a_bank2", bank_data[2], 8'ha2);
        cyc(0, 0, 2);
        check("pop2_start", start_select, 2);
        check("pop2_count", count, 1);
        check("pop2_lane0", lane(0), 8'ha2);
        cyc(4, 32'hb3b2b1b0, 0);
        check("b_count", count, 5);
        check("b_lane0", lane(0), 8'ha2);
        check("b_lane1", lane(1), 8'hb0);
        check("b_lane2", lane(2), 8'hb1);
        check("b_lane3", lane(3), 8'hb2);
        cyc(4, 32'hd3d2d1d0, 0);
        cyc(4, 32'he3e2e1e0, 0);
        cyc(3, 32'h00f2f1f0, 0);
        check("full_count", count, 16);
        check("full_free", free, 0);
        check("full_ovf", ovf, 0);
        cyc(1, 32'h000000ee, 0);
        check("ovf_pulse", ovf, 1);
        check("ovf_count", count, 16);
        cyc(0, 0, 0);
        check("ovf_clear", ovf, 0);
        cyc(1, 32'h000000ee, 4);
        check("mix_count", count, 12);
        check("mix_ovf", ovf, 1);
        check("mix_udf", udf, 0);
        check("mix_lane0", lane(0), 8'hb3);
        cyc(0, 0, 5);
        check("pop5_udf", udf, 1);
        check("pop5_count", count, 12);
        cyc(0, 0, 4);
        cyc(0, 0, 4);
        cyc(0, 0, 4);
        check("empty_count", count, 0);
        check("empty_free", free, 16);
        cyc(0, 0, 1);
        check("udf_pulse", udf, 1);
        check("udf_count", count, 0);
        cyc(0, 0, 0);
        check("noop_ovf", ovf, 0);
        check("noop_udf", udf, 0);
        cyc(5, 32'hffffffff, 0);
        check("push5_ovf", ovf, 1);
        check("push5_count", count, 0);
        for (int i = 0; i < 3; i++) cyc(4, 32'h11111111, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4);
        check("pre_wrap_count", count, 0);
        check("pre_wrap_start", start_select, 2);
        cyc(4, 32'hc3c2c1c0, 0);
        check("wrap_count", count, 4);
        check("wrap_bank2", bank_data[2], 8'hc0);
        check("wrap_bank3", bank_data[3], 8'hc1);
        check("wrap_bank0", bank_data[0], 8'hc2);
        check("wrap_bank1", bank_data[1], 8'hc3);
        for (int i = 0; i < 4; i++) check("wrap_lane", lane(i), 32'hc0 + i);
        cyc(0, 0, 4);
        check("wrap_pop_count", count, 0);
        check("wrap_pop_udf", udf, 0);
        check("wrap_pop_start", start_select, 2);
        cyc(2, 32'h00005a5b, 0);
        check("mid_count", count, 2);
        rst_n = 1'b0;
        cyc(4, 32'h01020304, 1);
        check("mid_rst_count", count, 0);
        check("mid_rst_free", free, 16);
        check("mid_rst_start", start_select, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_udf", udf, 0);
        rst_n = 1'b1;
        q.delete();
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  pc, pp;
            logic [31:0] pd;
            logic        pok, qok;
            pc = 3'($urandom_range(0, 5));
            pp = 3'($urandom_range(0, 5));
            pd = $urandom;
            rst_n = $urandom_range(0, 39) != 0;
            pok = pc <= 4 && int'(pc) <= 16 - q.size();
            qok = pp <= 4 && int'(pp) <= q.size();
            cyc(pc, pd, pp);
            if (!rst_n) begin
                q.delete();
                pok = 1'b1;
                qok = 1'b1;
            end else begin
                if (qok) for (int i = 0; i < pp; i++) void'(q.pop_front());
                if (pok) for (int i = 0; i < pc; i++) q.push_back(pd[8*i +: 8]);
            end
            check("rnd_count", count, q.size());
            check("rnd_ovf", ovf, !pok);
            check("rnd_udf", udf, !qok);
            for (int i = 0; i < 4 && i < q.size(); i++) check("rnd_lane", lane(i), q[i]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
